// File: rtl/data_mem_pkg.sv
// Shared encodings and lane helpers for the byte-addressed data memory.
package data_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic {CLEAR, IDLE} state_e;

  // Byte-lane mask within a 64-bit-wide view; narrower builds truncate it.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset,
                                         input int word_len);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = offset[0];
      SZ_W:    bad = (offset[1:0] != 2'b00);
      default: bad = (word_len == 32) || (offset != 3'b000);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_align.sv
// Store lane replication/masking and load lane extraction with sign/zero extension.
module data_mem_align
  import data_mem_pkg::*;
#(
  parameter  int WORD_LEN = 32,
  localparam int NB       = WORD_LEN / 8,
  localparam int BL       = $clog2(NB)
) (
  input  logic [1:0]          size_i,
  input  logic [BL-1:0]       offset_i,
  input  logic                unsigned_i,
  input  logic [WORD_LEN-1:0] wdata_i,
  input  logic [WORD_LEN-1:0] rword_i,
  output logic [NB-1:0]       wmask_o,
  output logic [WORD_LEN-1:0] wrep_o,
  output logic [WORD_LEN-1:0] rdata_o,
  output logic                misalign_o
);

  localparam logic [WORD_LEN-1:0] ONES = '1;

  logic [2:0]          off3;
  logic [WORD_LEN-1:0] shifted;
  logic [WORD_LEN-1:0] keep;
  logic                sgn;
  int                  nbits;

  always_comb begin
    off3             = '0;
    off3[BL-1:0]     = offset_i;
    wmask_o          = NB'(lane_mask(size_i, off3));
    misalign_o       = is_misaligned(size_i, off3, WORD_LEN);

    case (size_i)
      SZ_B:    wrep_o = {NB{wdata_i[7:0]}};
      SZ_H:    wrep_o = {(NB/2){wdata_i[15:0]}};
      SZ_W:    wrep_o = {(NB/4){wdata_i[31:0]}};
      default: wrep_o = wdata_i;
    endcase

    case (size_i)
      SZ_B:    nbits = 8;
      SZ_H:    nbits = 16;
      SZ_W:    nbits = 32;
      default: nbits = WORD_LEN;
    endcase
    if (nbits > WORD_LEN) nbits = WORD_LEN;

    // Bring the addressed lanes down to bit 0; keep marks the live field.
    shifted = rword_i >> {offset_i, 3'b000};
    keep    = ONES >> (WORD_LEN - nbits);
    sgn     = |(shifted & keep & ~(keep >> 1));
    rdata_o = (shifted & keep) | ((sgn && !unsigned_i) ? ~keep : '0);
  end

endmodule

// File: rtl/data_mem_pipe.sv
// Byte-addressed data memory with request handshake, clear engine and fixed-latency responses.
module data_mem_pipe
  import data_mem_pkg::*;
#(
  parameter  int WORD_LEN   = 32,
  parameter  int DEPTH      = 1024,
  parameter  int RD_LAT     = 1,
  parameter  int CLR_ON_RST = 1,
  localparam int NB         = WORD_LEN / 8,
  localparam int BL         = $clog2(NB),
  localparam int IW         = $clog2(DEPTH),
  localparam int AW         = IW + BL
) (
  input  logic                i_CLK,
  input  logic                i_RSTN,
  input  logic                i_Req,
  output logic                o_Ready,
  input  logic                i_We,
  input  logic [1:0]          i_Size,
  input  logic                i_Unsigned,
  input  logic [AW-1:0]       i_Addr,
  input  logic [WORD_LEN-1:0] i_Wdata,
  output logic                o_Rvalid,
  output logic [WORD_LEN-1:0] o_Rdata,
  output logic                o_Misalign,
  output logic                o_Busy,
  input  logic [IW-1:0]       i_Test_Addr,
  output logic [WORD_LEN-1:0] o_Test_Data
);

  state_e              state_q;
  logic [IW-1:0]       cnt_q;
  logic                busy_q;
  logic                ready_q;

  logic [WORD_LEN-1:0] mem [DEPTH];

  logic [IW-1:0]       widx;
  logic                accept;
  logic                wr_en;
  logic [WORD_LEN-1:0] rword;
  logic [NB-1:0]       wmask;
  logic [WORD_LEN-1:0] wrep;
  logic [WORD_LEN-1:0] rext;
  logic                mis;

  logic                rv_d;
  logic                mis_d;
  logic [WORD_LEN-1:0] dat_d;
  logic                rv_q  [RD_LAT];
  logic                mis_q [RD_LAT];
  logic [WORD_LEN-1:0] dat_q [RD_LAT];

  assign widx   = i_Addr[AW-1:BL];
  assign accept = i_Req & ready_q;
  assign rword  = mem[widx];
  assign wr_en  = accept & i_We & ~mis;

  data_mem_align #(.WORD_LEN(WORD_LEN)) u_align (
    .size_i     (i_Size),
    .offset_i   (i_Addr[BL-1:0]),
    .unsigned_i (i_Unsigned),
    .wdata_i    (i_Wdata),
    .rword_i    (rword),
    .wmask_o    (wmask),
    .wrep_o     (wrep),
    .rdata_o    (rext),
    .misalign_o (mis)
  );

  // Ready and busy are registered so o_Ready never depends on i_Req.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      if (CLR_ON_RST != 0) state_q <= CLEAR;
      else                 state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= (CLR_ON_RST != 0);
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + IW'(1);
          if (cnt_q == IW'(DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (state_q == CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask[b]) mem[widx][8*b +: 8] <= wrep[8*b +: 8];
      end
    end
  end

  // Response entry captured on the accept edge; data is zero unless a legal load.
  always_comb begin
    rv_d  = accept & ~i_We;
    mis_d = accept & mis;
    dat_d = (accept && !i_We && !mis) ? rext : '0;
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      for (int i = 0; i < RD_LAT; i++) begin
        rv_q[i]  <= 1'b0;
        mis_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      rv_q[0]  <= rv_d;
      mis_q[0] <= mis_d;
      dat_q[0] <= dat_d;
      for (int i = 1; i < RD_LAT; i++) begin
        rv_q[i]  <= rv_q[i-1];
        mis_q[i] <= mis_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign o_Ready     = ready_q;
  assign o_Busy      = busy_q;
  assign o_Rvalid    = rv_q[RD_LAT-1];
  assign o_Misalign  = mis_q[RD_LAT-1];
  assign o_Rdata     = dat_q[RD_LAT-1];
  assign o_Test_Data = mem[i_Test_Addr];

endmodule

// File: tb/tb_data_mem_pipe.sv
// Randomized and directed bench for data_mem_pipe against a byte-array reference model.
module tb_data_mem_pipe;

  localparam int WORD_LEN = 32;
  localparam int DEPTH    = 1024;
  localparam int RD_LAT   = 3;
  localparam int IW       = 10;
  localparam int AW       = 12;
  localparam int NBYTES   = DEPTH * 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                req, we, uns;
  logic [1:0]          size;
  logic [AW-1:0]       addr;
  logic [WORD_LEN-1:0] wdata;
  logic [IW-1:0]       taddr;
  logic                ready, rvalid, misal, busy;
  logic [WORD_LEN-1:0] rdata, tdata;

  always #5 clk = ~clk;

  data_mem_pipe #(.WORD_LEN(WORD_LEN), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .CLR_ON_RST(1)) dut (
    .i_CLK(clk), .i_RSTN(rst_n), .i_Req(req), .o_Ready(ready), .i_We(we), .i_Size(size),
    .i_Unsigned(uns), .i_Addr(addr), .i_Wdata(wdata), .o_Rvalid(rvalid), .o_Rdata(rdata),
    .o_Misalign(misal), .o_Busy(busy), .i_Test_Addr(taddr), .o_Test_Data(tdata)
  );

  typedef struct {
    int          due;
    bit          rv;
    bit          mis;
    logic [31:0] data;
  } resp_t;

  resp_t       q[$];
  logic [7:0]  mmem [NBYTES];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_chk = 0;
  bit          mon_en = 0;
  logic [33:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mword(input int w);
    return {mmem[4*w+3], mmem[4*w+2], mmem[4*w+1], mmem[4*w]};
  endfunction

  // Every cycle the output triple must match the scheduled response, or be all-zero.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_exp = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        mon_exp = {q[0].rv, q[0].mis, q[0].data};
        void'(q.pop_front());
      end
      check("resp", {rvalid, misal, rdata}, mon_exp);
    end
  end

  task automatic issue(input bit w, input logic [1:0] sz, input bit u, input int a,
                       input logic [31:0] d, input bit use_exp, input logic [31:0] expv);
    int          nb;
    bit          bad;
    logic [31:0] v;
    resp_t       r;
    @(negedge clk);
    check("ready", ready, 1);
    req = 1'b1; we = w; size = sz; uns = u; addr = a[AW-1:0]; wdata = d;
    nb  = 1 << sz;
    bad = (nb > 4) || (a % nb != 0);
    v   = '0;
    if (!bad) begin
      for (int b = 0; b < nb; b++) begin
        if (w) mmem[a+b] = d[8*b +: 8];
        else   v = v | (32'(mmem[a+b]) << (8*b));
      end
      if (!w && !u && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
    end
    if (use_exp) v = expv;
    if (!w || bad) begin
      r.due  = cyc + RD_LAT;
      r.rv   = !w;
      r.mis  = bad;
      r.data = (!w && !bad) ? v : 32'd0;
      q.push_back(r);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req = 1'b0;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NBYTES; i++) mmem[i] = 8'h00;
  endtask

  task automatic wait_clear();
    int n;
    bit rdy_seen;
    n = 0;
    rdy_seen = 0;
    while (busy && n < 3000) begin
      if (ready) rdy_seen = 1;
      n++;
      @(negedge clk);
    end
    check("busy_len", n, DEPTH);
    check("ready_in_clear", rdy_seen, 0);
    check("ready_after", ready, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = 1'b0;
    rst_n = 1'b0;
    q.delete();
    clear_model();
    #1;
    check("rst_busy", busy, 1);
    check("rst_ready", ready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_clear();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = '0; wdata = '0; taddr = '0;
    repeat (2) @(posedge clk);
    mon_en = 1;
    do_reset();

    // Reset clears stored data
    issue(1, 2'b10, 0, 'h40, 32'hCAFEBABE, 0, 0);
    idle(1);
    taddr = 10'd16;
    #1 check("tp_pre_clear", tdata, 32'hCAFEBABE);
    do_reset();
    taddr = 10'd16;
    #1 check("tp_post_clear", tdata, 32'h0);
    issue(0, 2'b10, 0, 'h40, 0, 1, 32'h0);
    idle(RD_LAT + 1);

    // Byte store and loads
    issue(1, 2'b10, 0, 'h0, 32'h11223344, 0, 0);
    issue(1, 2'b00, 0, 'h3, 32'h000000A5, 0, 0);
    issue(0, 2'b10, 0, 'h0, 0, 1, 32'hA5223344);
    issue(0, 2'b00, 0, 'h3, 0, 1, 32'hFFFFFFA5);
    issue(0, 2'b00, 1, 'h3, 0, 1, 32'h000000A5);

    // Half store and loads
    issue(1, 2'b10, 0, 'h4, 32'h0, 0, 0);
    issue(1, 2'b01, 0, 'h6, 32'h00008001, 0, 0);
    issue(0, 2'b01, 0, 'h6, 0, 1, 32'hFFFF8001);
    issue(0, 2'b01, 1, 'h6, 0, 1, 32'h00008001);
    issue(0, 2'b10, 0, 'h4, 0, 1, 32'h80010000);

    // Misaligned accesses
    issue(0, 2'b10, 0, 'h2, 0, 0, 0);
    issue(1, 2'b10, 0, 'h1, 32'hDEADBEEF, 0, 0);
    issue(1, 2'b11, 0, 'h0, 32'h12345678, 0, 0);
    issue(0, 2'b11, 0, 'h8, 0, 0, 0);
    idle(RD_LAT + 1);
    taddr = 10'd0;
    #1 check("tp_word0_kept", tdata, 32'hA5223344);

    // Back-to-back loads through the pipeline
    issue(1, 2'b10, 0, 'h8, 32'h5A5A5A5A, 0, 0);
    issue(0, 2'b10, 0, 'h8, 0, 1, 32'h5A5A5A5A);
    issue(0, 2'b10, 0, 'h0, 0, 1, 32'hA5223344);
    issue(0, 2'b10, 0, 'h8, 0, 1, 32'h5A5A5A5A);
    issue(0, 2'b10, 0, 'h4, 0, 1, 32'h80010000);
    idle(RD_LAT + 2);
    check("drain_directed", q.size(), 0);

    // Reset with responses in flight
    issue(0, 2'b10, 0, 'h8, 0, 1, 32'h5A5A5A5A);
    issue(0, 2'b10, 0, 'h0, 0, 1, 32'hA5223344);
    idle(1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rvalid", rvalid, 0);
    check("async_rdata", rdata, 0);
    check("async_busy", busy, 1);
    q.delete();
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_clear();

    // Random traffic over a small window to force overlap
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 63)), $urandom, 0, 0);
    end
    idle(RD_LAT + 2);
    check("drain_random", q.size(), 0);
    for (int w = 0; w < 16; w++) begin
      taddr = IW'(w);
      #1 check("tp_sweep", tdata, mword(w));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
